test_loop_ctrl: RTL and testbench

- Sequencer for the MAC loopback self-test: arms the receive checker, issues frame-start pulses to the transmit frame generator, and waits for each frame to come back.
- Applies inter-frame gaps and a per-frame timeout.
- Counts sent, good and bad frames, and stops on completion, checker error or timeout.
- Sits between the control register block and the test_tx/test_rx pair on the MAC user clock.

---
 rtl/test_loop_ctrl.sv | 166 ++++++++++++++++
 tb/tb_test_loop_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/test_loop_ctrl.sv
// Loopback self-test sequencer: arms the RX checker, pulses TX frame starts,
// waits for each frame to return, and keeps sent/good/bad frame statistics.
module test_loop_ctrl #(
  parameter int FRAME_LEN   = 64,
  parameter int GAP_CYC     = 12,
  parameter int ARM_CYC     = 2,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [15:0]      frame_num,
  output logic             tx_start,
  output logic [15:0]      tx_len,
  output logic             rx_start,
  input  logic             rx_err,
  input  logic             mac_rx_valid,
  input  logic             mac_rx_eof,
  input  logic             mac_rx_fr_good,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic             timeout,
  output logic [CNT_W-1:0] tx_cnt,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] bad_cnt,
  output logic [2:0]       o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_RX = 3'd3,
    S_GAP     = 3'd4,
    S_DONE    = 3'd5,
    S_FAIL    = 3'd6
  } state_t;

  // One down-counter is shared by the arm, gap and timeout phases.
  localparam int TW = $clog2(TIMEOUT_CYC + GAP_CYC + ARM_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state, w_next;
  logic [TW-1:0]    r_tmr, w_tmr_next;
  logic             r_run_q;
  logic [CNT_W-1:0] r_tx_cnt, r_ok_cnt, r_bad_cnt, w_ok_new;
  logic             r_done, r_fail, r_tmo;
  logic             w_busy, w_start, w_abort, w_good_eof, w_bad_eof;
  logic             w_ok_inc, w_bad_inc, w_set_tmo;

  assign w_busy     = (r_state == S_ARM) || (r_state == S_SEND) ||
                      (r_state == S_WAIT_RX) || (r_state == S_GAP);
  assign w_start    = (r_state == S_IDLE) && run && !r_run_q;
  assign w_abort    = w_busy && !run;
  assign w_good_eof = mac_rx_valid & mac_rx_eof & mac_rx_fr_good;
  assign w_bad_eof  = mac_rx_valid & mac_rx_eof & ~mac_rx_fr_good;
  assign w_ok_inc   = (r_state == S_WAIT_RX) && w_good_eof && !w_abort;
  assign w_bad_inc  = (r_state == S_WAIT_RX) && w_bad_eof && !w_abort;
  assign w_ok_new   = (r_ok_cnt == CNT_MAX) ? r_ok_cnt : r_ok_cnt + CNT_W'(1);

  always_comb begin
    w_next     = r_state;
    w_tmr_next = r_tmr;
    w_set_tmo  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next     = S_ARM;
          w_tmr_next = TW'(ARM_CYC - 1);
        end
      end
      S_ARM: begin
        if (r_tmr == '0) w_next = S_SEND;
        else             w_tmr_next = r_tmr - TW'(1);
      end
      S_SEND: begin
        w_next     = S_WAIT_RX;
        w_tmr_next = TW'(TIMEOUT_CYC);
      end
      S_WAIT_RX: begin
        w_tmr_next = r_tmr - TW'(1);
        if (w_bad_eof) begin
          w_next = S_FAIL;
        end else if (w_good_eof) begin
          // A frame_num already below ok_cnt never matches, so the test runs on.
          if ((frame_num != 16'd0) && (w_ok_new == CNT_W'(frame_num))) begin
            w_next = S_DONE;
          end else begin
            w_next     = S_GAP;
            w_tmr_next = TW'(GAP_CYC - 1);
          end
        end else if (r_tmr == TW'(1)) begin
          w_next    = S_FAIL;
          w_set_tmo = 1'b1;
        end
      end
      S_GAP: begin
        if (r_tmr == '0) w_next = S_SEND;
        else             w_tmr_next = r_tmr - TW'(1);
      end
      S_DONE:  if (!run) w_next = S_IDLE;
      S_FAIL:  if (!run) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_busy && rx_err) begin
      w_next    = S_FAIL;
      w_set_tmo = 1'b0;
    end
    if (w_abort) begin
      w_next    = S_IDLE;
      w_set_tmo = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_tmr     <= '0;
      r_run_q   <= 1'b0;
      r_tx_cnt  <= '0;
      r_ok_cnt  <= '0;
      r_bad_cnt <= '0;
      r_done    <= 1'b0;
      r_fail    <= 1'b0;
      r_tmo     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tmr   <= w_tmr_next;
      r_run_q <= run;
      if (w_start) begin
        r_tx_cnt  <= '0;
        r_ok_cnt  <= '0;
        r_bad_cnt <= '0;
      end else begin
        // Every issued tx_start pulse is counted, even if run drops that cycle.
        if (r_state == S_SEND && r_tx_cnt != CNT_MAX) r_tx_cnt <= r_tx_cnt + CNT_W'(1);
        if (w_ok_inc) r_ok_cnt <= w_ok_new;
        if (w_bad_inc && r_bad_cnt != CNT_MAX) r_bad_cnt <= r_bad_cnt + CNT_W'(1);
      end
      if (w_start || w_abort) begin
        r_done <= 1'b0;
        r_fail <= 1'b0;
        r_tmo  <= 1'b0;
      end else begin
        if (w_next == S_DONE) r_done <= 1'b1;
        if (w_next == S_FAIL) r_fail <= 1'b1;
        if (w_set_tmo)        r_tmo  <= 1'b1;
      end
    end
  end

  assign tx_start    = (r_state == S_SEND);
  assign tx_len      = 16'(FRAME_LEN);
  assign rx_start    = w_busy;
  assign busy        = w_busy;
  assign done        = r_done;
  assign fail        = r_fail;
  assign timeout     = r_tmo;
  assign tx_cnt      = r_tx_cnt;
  assign ok_cnt      = r_ok_cnt;
  assign bad_cnt     = r_bad_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_test_loop_ctrl.sv
// Directed bench for test_loop_ctrl with a 16-cycle frame timeout and default
// arm/gap lengths; expected values are worked out by hand from the behaviour.
module tb_test_loop_ctrl;

  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst, run, rx_err, mac_rx_valid, mac_rx_eof, mac_rx_fr_good;
  logic [15:0]      frame_num;
  logic             tx_start, rx_start, busy, done, fail, timeout;
  logic [15:0]      tx_len;
  logic [CNT_W-1:0] tx_cnt, ok_cnt, bad_cnt;
  logic [2:0]       dbg_state;

  int n_cmp   = 0;
  int n_err   = 0;
  int tx_seen = 0;

  always #5 clk = ~clk;

  test_loop_ctrl #(.TIMEOUT_CYC(16)) u_dut (
    .clk(clk), .rst(rst), .run(run), .frame_num(frame_num),
    .tx_start(tx_start), .tx_len(tx_len), .rx_start(rx_start), .rx_err(rx_err),
    .mac_rx_valid(mac_rx_valid), .mac_rx_eof(mac_rx_eof), .mac_rx_fr_good(mac_rx_fr_good),
    .busy(busy), .done(done), .fail(fail), .timeout(timeout),
    .tx_cnt(tx_cnt), .ok_cnt(ok_cnt), .bad_cnt(bad_cnt), .o_dbg_state(dbg_state)
  );

  always @(negedge clk) if (tx_start === 1'b1) tx_seen <= tx_seen + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Steps until tx_start is seen; n is the number of steps taken (100 = gave up).
  task automatic wait_tx(output int n);
    n = 0;
    while (tx_start !== 1'b1 && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic eof_pulse(input logic good);
    mac_rx_valid = 1'b1; mac_rx_eof = 1'b1; mac_rx_fr_good = good;
    step();
    mac_rx_valid = 1'b0; mac_rx_eof = 1'b0; mac_rx_fr_good = 1'b0;
  endtask

  // From the SEND cycle: EOF arrives in the dly-th WAIT_RX cycle.
  task automatic frame_rtn(input int dly, input logic good);
    repeat (dly) step();
    eof_pulse(good);
  endtask

  initial begin
    int n;
    int base;
    rst = 1'b0; run = 1'b0; frame_num = 16'd0; rx_err = 1'b0;
    mac_rx_valid = 1'b0; mac_rx_eof = 1'b0; mac_rx_fr_good = 1'b0;
    repeat (2) step();
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_rx_start", rx_start, 0);
    chk("rst_flags", {done, fail, timeout}, 0);
    chk("rst_cnts", tx_cnt | ok_cnt | bad_cnt, 0);
    chk("tx_len", tx_len, 64);
    rst = 1'b1;
    step();

    // Three good frames, one returning on the last cycle before timeout.
    frame_num = 16'd3;
    run = 1'b1;
    wait_tx(n);
    chk("t1_first_tx_latency", n, 3);
    chk("t1_rx_start_armed", rx_start, 1);
    frame_rtn(3, 1'b1);
    wait_tx(n);
    chk("t1_gap_latency", n + 1, 13);
    chk("t1_ok_after_1", ok_cnt, 1);
    chk("t1_tx_after_1", tx_cnt, 1);
    frame_rtn(16, 1'b1);
    chk("t1_eof_at_expiry_state", dbg_state, 4);
    wait_tx(n);
    chk("t1_gap_latency2", n + 1, 13);
    frame_rtn(2, 1'b1);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_rx_start", rx_start, 0);
    chk("t1_ok_cnt", ok_cnt, 3);
    chk("t1_bad_cnt", bad_cnt, 0);
    chk("t1_tx_cnt", tx_cnt, 3);
    chk("t1_tx_pulses", tx_seen, 3);
    chk("t1_state", dbg_state, 5);
    repeat (3) step();
    chk("t1_done_hold", done, 1);
    run = 1'b0;
    step();
    chk("t1_idle_state", dbg_state, 0);
    chk("t1_done_kept_in_idle", done, 1);

    // Second frame comes back with a bad CRC.
    frame_num = 16'd5;
    run = 1'b1;
    step();
    chk("t2_start_clears_done", done, 0);
    chk("t2_start_clears_ok", ok_cnt, 0);
    wait_tx(n);
    frame_rtn(3, 1'b1);
    wait_tx(n);
    frame_rtn(4, 1'b0);
    chk("t2_fail", fail, 1);
    chk("t2_timeout", timeout, 0);
    chk("t2_bad_cnt", bad_cnt, 1);
    chk("t2_ok_cnt", ok_cnt, 1);
    chk("t2_tx_cnt", tx_cnt, 2);
    chk("t2_busy", busy, 0);
    run = 1'b0;
    repeat (2) step();
    chk("t2_fail_hold", fail, 1);

    // No frame returned: 16 cycles in WAIT_RX, then timeout.
    run = 1'b1;
    wait_tx(n);
    repeat (16) step();
    chk("t3_still_waiting", dbg_state, 3);
    chk("t3_no_fail_yet", fail, 0);
    step();
    chk("t3_fail", fail, 1);
    chk("t3_timeout", timeout, 1);
    chk("t3_tx_cnt", tx_cnt, 1);
    chk("t3_busy", busy, 0);
    run = 1'b0;
    step();

    // rx_err together with a good EOF.
    run = 1'b1;
    wait_tx(n);
    repeat (3) step();
    rx_err = 1'b1;
    eof_pulse(1'b1);
    rx_err = 1'b0;
    chk("t4_ok_cnt", ok_cnt, 1);
    chk("t4_state", dbg_state, 6);
    chk("t4_fail", fail, 1);
    chk("t4_timeout", timeout, 0);
    run = 1'b0;
    step();

    // Continuous run aborted after 7 frames.
    frame_num = 16'd0;
    run = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_tx(n);
      chk("t5_tx_spacing", n, (i == 0) ? 3 : 12);
      frame_rtn(2, 1'b1);
    end
    chk("t5_tx_cnt_7", tx_cnt, 7);
    chk("t5_ok_cnt_7", ok_cnt, 7);
    run = 1'b0;
    step();
    chk("t5_abort_state", dbg_state, 0);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_tx_cnt", tx_cnt, 7);
    chk("t5_abort_ok_cnt", ok_cnt, 7);
    chk("t5_abort_flags", {done, fail}, 0);
    base = tx_seen;
    repeat (20) step();
    chk("t5_no_tx_after_abort", tx_seen - base, 0);

    // Rerun, then asynchronous reset in the middle of GAP.
    run = 1'b1;
    wait_tx(n);
    chk("t5_rerun_latency", n, 3);
    frame_rtn(2, 1'b1);
    repeat (3) step();
    chk("t5_mid_gap", dbg_state, 4);
    #2;
    rst = 1'b0;
    run = 1'b0;
    #1;
    chk("t5_rst_state", dbg_state, 0);
    chk("t5_rst_busy", {busy, rx_start, tx_start}, 0);
    chk("t5_rst_cnts", tx_cnt | ok_cnt | bad_cnt, 0);
    chk("t5_rst_tx_len", tx_len, 64);
    repeat (2) step();
    rst = 1'b1;
    base = tx_seen;
    repeat (5) step();
    chk("t5_idle_after_rst", busy, 0);
    chk("t5_no_tx_after_rst", tx_seen - base, 0);
    run = 1'b1;
    wait_tx(n);
    chk("t5_restart_latency", n, 3);
    run = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
